// File: rtl/mac_bist_pkg.sv
// Shared types and constants for the MAC slice BIST controller.
package mac_bist_pkg;

    localparam int unsigned N_LANES = 256;
    localparam int unsigned W_BITS  = 4;
    localparam int unsigned SUM_W   = 16;
    localparam int unsigned IDX_W   = 8;
    localparam int unsigned EXP_ONE = 15;
    localparam int unsigned EXP_TWO = 30;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_S1_RUN = 3'd1,
        ST_GAP    = 3'd2,
        ST_S2_RUN = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        FT_NONE         = 3'd0,
        FT_SAF          = 3'd1,
        FT_WIRED_AND    = 3'd2,
        FT_DOMINANT     = 3'd3,
        FT_DOMINANT_AND = 3'd4,
        FT_WIRED_OR     = 3'd5
    } fault_t;

    // Bridge classification of two consecutive stage-2 sums, in priority order.
    function automatic fault_t classify_bridge(input logic [SUM_W-1:0] prev,
                                               input logic [SUM_W-1:0] cur);
        logic [SUM_W-1:0] one;
        logic [SUM_W-1:0] two;
        one = SUM_W'(EXP_ONE);
        two = SUM_W'(EXP_TWO);
        if (prev == '0 && cur == '0)
            return FT_WIRED_AND;
        else if ((prev == two && cur == '0) || (prev == '0 && cur == two))
            return FT_DOMINANT;
        else if (prev == '0 && cur == one)
            return FT_DOMINANT_AND;
        else if (prev == two && cur == two)
            return FT_WIRED_OR;
        else
            return FT_NONE;
    endfunction

endpackage

// File: rtl/mac_bist_onehot.sv
// Registered 8->256 one-hot decoder with a zero-force input.
//   clk, rst : clock, synchronous active-high reset
//   sel      : lane index to set
//   zero     : force all-zero output
//   onehot   : registered decoded pattern
module mac_bist_onehot
    import mac_bist_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [IDX_W-1:0]   sel,
    input  logic               zero,
    output logic [N_LANES-1:0] onehot
);

    always_ff @(posedge clk) begin
        if (rst || zero)
            onehot <= '0;
        else
            onehot <= N_LANES'(1) << sel;
    end

endmodule

// File: rtl/mac_fault_bist_ctrl.sv
// BIST controller for the MAC slice: drives walking-one/weight patterns,
// samples the returned sum and reports the first fault found.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a test from IDLE or DONE
//   in_array     : walking-one lane pattern to the MAC
//   weight_array : all-zero (stage 1) or all-one (gap/stage 2) weights
//   sum          : MAC result
//   busy, done   : test running / test finished
//   pass         : no fault found (valid with done)
//   fault_*      : type, lane index, SAF weight nibble and raw sum at detection
module mac_fault_bist_ctrl
    import mac_bist_pkg::*;
#(
    parameter int unsigned MAC_LATENCY = 1,
    parameter int unsigned SETTLE      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic [N_LANES-1:0]        in_array,
    output logic [N_LANES*W_BITS-1:0] weight_array,
    input  logic [SUM_W-1:0]          sum,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [2:0]                fault_type,
    output logic [IDX_W-1:0]          fault_index,
    output logic [W_BITS-1:0]         fault_weight,
    output logic [SUM_W-1:0]          fault_sum
);

    localparam int unsigned LAT_W = $clog2(MAC_LATENCY + 2);
    localparam int unsigned GAP_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [SUM_W-1:0]   prev_q, prev_d;
    logic               wone_q, wone_d;
    logic               busy_d, done_d, pass_d;
    fault_t             ft_q, ft_d;
    logic [IDX_W-1:0]   fi_d;
    logic [W_BITS-1:0]  fw_d;
    logic [SUM_W-1:0]   fs_d;
    logic               sample, last_idx, zero_d;
    fault_t             hit;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            lat_q        <= '0;
            gap_q        <= '0;
            prev_q       <= '0;
            wone_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            ft_q         <= FT_NONE;
            fault_index  <= '0;
            fault_weight <= '0;
            fault_sum    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            gap_q        <= gap_d;
            prev_q       <= prev_d;
            wone_q       <= wone_d;
            busy         <= busy_d;
            done         <= done_d;
            pass         <= pass_d;
            ft_q         <= ft_d;
            fault_index  <= fi_d;
            fault_weight <= fw_d;
            fault_sum    <= fs_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        lat_d    = lat_q;
        gap_d    = gap_q;
        prev_d   = prev_q;
        wone_d   = wone_q;
        busy_d   = busy;
        done_d   = done;
        pass_d   = pass;
        ft_d     = ft_q;
        fi_d     = fault_index;
        fw_d     = fault_weight;
        fs_d     = fault_sum;
        sample   = (lat_q == LAT_W'(MAC_LATENCY));
        last_idx = (idx_q == IDX_W'(N_LANES - 1));
        hit      = classify_bridge(prev_q, sum);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_S1_RUN;
                    idx_d   = '0;
                    lat_d   = '0;
                    wone_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    ft_d    = FT_NONE;
                    fi_d    = '0;
                    fw_d    = '0;
                    fs_d    = '0;
                end
            end
            ST_S1_RUN: begin
                if (!sample) begin
                    lat_d = lat_q + LAT_W'(1);
                end else if (sum != '0) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ft_d    = FT_SAF;
                    fi_d    = idx_q;
                    fw_d    = sum[W_BITS-1:0];
                    fs_d    = sum;
                end else if (last_idx) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    wone_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                    lat_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_W'(SETTLE - 1)) begin
                    state_d = ST_S2_RUN;
                    idx_d   = '0;
                    lat_d   = '0;
                    prev_d  = SUM_W'(EXP_ONE);
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_S2_RUN: begin
                if (!sample) begin
                    lat_d = lat_q + LAT_W'(1);
                end else if (hit != FT_NONE) begin
                    state_d = ST_DONE;
                    wone_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ft_d    = hit;
                    fi_d    = idx_q;
                    fs_d    = sum;
                end else if (last_idx) begin
                    state_d = ST_DONE;
                    wone_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    prev_d = sum;
                    idx_d  = idx_q + IDX_W'(1);
                    lat_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wone_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase

        zero_d = !((state_d == ST_S1_RUN) || (state_d == ST_S2_RUN));
    end

    mac_bist_onehot u_onehot (
        .clk    (clk),
        .rst    (rst),
        .sel    (idx_d),
        .zero   (zero_d),
        .onehot (in_array)
    );

    assign weight_array = {(N_LANES*W_BITS){wone_q}};
    assign fault_type   = ft_q;

endmodule

// File: tb/tb_mac_fault_bist_ctrl.sv
// Directed bench for mac_fault_bist_ctrl with a behavioural MAC slice model
// supporting an injected SAF, a lane 20/21 bridge and an isolated odd sum.
module tb_mac_fault_bist_ctrl;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [255:0]  in_array;
    logic [1023:0] weight_array;
    logic [15:0]   sum = '0;
    logic          busy, done, pass;
    logic [2:0]    fault_type;
    logic [7:0]    fault_index;
    logic [3:0]    fault_weight;
    logic [15:0]   fault_sum;

    int ncmp = 0;
    int nfail = 0;
    int e = 0;

    logic saf_en = 1'b0;
    logic br_en  = 1'b0;
    logic iso_en = 1'b0;
    logic [15:0] br_a = '0;
    logic [15:0] br_b = '0;

    mac_fault_bist_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_array     (in_array),
        .weight_array (weight_array),
        .sum          (sum),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fault_type   (fault_type),
        .fault_index  (fault_index),
        .fault_weight (fault_weight),
        .fault_sum    (fault_sum)
    );

    always #5 clk = ~clk;

    // MAC slice model: sum of in*weight, with optional injected faults.
    function automatic logic [15:0] mac_fn(input logic [255:0] iv, input logic [1023:0] wv);
        int s;
        int act;
        logic [3:0] w;
        s = 0;
        act = -1;
        for (int i = 0; i < 256; i++) begin
            w = wv[4*i +: 4];
            if (saf_en && i == 11) w = 4'hF;
            if (iv[i]) begin
                s = s + int'(w);
                act = i;
            end
        end
        if (wv != '0) begin
            if (br_en && act == 20) s = int'(br_a);
            if (br_en && act == 21) s = int'(br_b);
            if (iso_en && act == 40) s = 7;
        end
        return 16'(s);
    endfunction

    always @(posedge clk) sum <= mac_fn(in_array, weight_array);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
    endtask

    task automatic adv_to(input int target);
        while (e < target) begin
            @(posedge clk);
            e++;
        end
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 0);
        chk({tag, "_ftype"}, 32'(fault_type), 0);
        chk({tag, "_fidx"}, 32'(fault_index), 0);
        chk({tag, "_fw"}, 32'(fault_weight), 0);
        chk({tag, "_fsum"}, 32'(fault_sum), 0);
        chk({tag, "_in_cnt"}, 32'($countones(in_array)), 0);
        chk({tag, "_w_cnt"}, 32'($countones(weight_array)), 0);
    endtask

    logic [15:0] br_tab_a [4] = '{16'd0, 16'd30, 16'd30, 16'd0};
    logic [15:0] br_tab_b [4] = '{16'd0, 16'd30, 16'd0, 16'd15};
    logic [2:0]  br_tab_t [4] = '{3'd2, 3'd5, 3'd3, 3'd4};

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_idle_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fault-free run.
        pulse_start();
        chk("ff_busy_e0", 32'(busy), 1);
        chk("ff_in_cnt_e0", 32'($countones(in_array)), 1);
        chk("ff_in0_e0", 32'(in_array[0]), 1);
        adv_to(2);
        chk("ff_in1_e2", 32'(in_array[1]), 1);
        adv_to(512);
        chk("ff_gap_in", 32'($countones(in_array)), 0);
        chk("ff_gap_w", 32'($countones(weight_array)), 1024);
        chk("ff_gap_busy", 32'(busy), 1);
        adv_to(514);
        chk("ff_s2_in0", 32'(in_array[0]), 1);
        adv_to(1025);
        chk("ff_done_e1025", 32'(done), 0);
        adv_to(1026);
        chk("ff_done", 32'(done), 1);
        chk("ff_pass", 32'(pass), 1);
        chk("ff_ftype", 32'(fault_type), 0);
        chk("ff_busy_end", 32'(busy), 0);
        chk("ff_in_end", 32'($countones(in_array)), 0);
        chk("ff_w_end", 32'($countones(weight_array)), 0);

        // SAF on lane 11, with a start pulse during busy that must be ignored.
        saf_en = 1'b1;
        pulse_start();
        adv_to(10);
        start = 1'b1;
        adv_to(11);
        start = 1'b0;
        chk("saf_busy_mid", 32'(busy), 1);
        adv_to(23);
        chk("saf_done_e23", 32'(done), 0);
        adv_to(24);
        chk("saf_done", 32'(done), 1);
        chk("saf_ftype", 32'(fault_type), 1);
        chk("saf_fidx", 32'(fault_index), 11);
        chk("saf_fw", 32'(fault_weight), 15);
        chk("saf_fsum", 32'(fault_sum), 15);
        chk("saf_pass", 32'(pass), 0);
        chk("saf_busy", 32'(busy), 0);
        chk("saf_in", 32'($countones(in_array)), 0);

        // Restart from DONE clears fields and repeats the timing.
        pulse_start();
        chk("re_ftype_clr", 32'(fault_type), 0);
        chk("re_fidx_clr", 32'(fault_index), 0);
        chk("re_fsum_clr", 32'(fault_sum), 0);
        chk("re_done_clr", 32'(done), 0);
        chk("re_busy", 32'(busy), 1);
        adv_to(23);
        chk("re_done_e23", 32'(done), 0);
        adv_to(24);
        chk("re_ftype", 32'(fault_type), 1);
        chk("re_fidx", 32'(fault_index), 11);
        saf_en = 1'b0;

        // Bridges on lanes 20/21.
        br_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            br_a = br_tab_a[k];
            br_b = br_tab_b[k];
            pulse_start();
            adv_to(557);
            chk($sformatf("br%0d_done_e557", k), 32'(done), 0);
            adv_to(558);
            chk($sformatf("br%0d_done", k), 32'(done), 1);
            chk($sformatf("br%0d_ftype", k), 32'(fault_type), 32'(br_tab_t[k]));
            chk($sformatf("br%0d_fidx", k), 32'(fault_index), 21);
            chk($sformatf("br%0d_fsum", k), 32'(fault_sum), 32'(br_tab_b[k]));
            chk($sformatf("br%0d_pass", k), 32'(pass), 0);
        end
        br_en = 1'b0;

        // Isolated unmatched sum never stops the test.
        iso_en = 1'b1;
        pulse_start();
        adv_to(1025);
        chk("iso_done_e1025", 32'(done), 0);
        adv_to(1026);
        chk("iso_done", 32'(done), 1);
        chk("iso_pass", 32'(pass), 1);
        chk("iso_ftype", 32'(fault_type), 0);
        iso_en = 1'b0;

        // Reset mid-stage-2 aborts with no report.
        pulse_start();
        adv_to(714);
        chk("rst_in100", 32'(in_array[100]), 1);
        rst = 1'b1;
        adv_to(715);
        chk_idle_zero("midrst");
        rst = 1'b0;
        adv_to(720);
        chk("midrst_done_later", 32'(done), 0);
        chk("midrst_busy_later", 32'(busy), 0);
        chk("midrst_in_later", 32'($countones(in_array)), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/mac_fault_bist_ctrl.md
# mac_fault_bist_ctrl

Built-in self-test controller for the faulty MAC slice (`mac_slice_faulty_general`). It drives walking-one input patterns and all-zero/all-one weight arrays into the slice, and samples the returned `sum`. It classifies the first stuck-at or bridging fault it finds and reports it. It replaces the behavioural detection bench with synthesizable logic, sitting both upstream (stimulus) and downstream (response analysis) of the MAC slice.

## Interface
Parameters:
- `MAC_LATENCY`, default 1: edges from MAC input capture to valid `sum`.
- `SETTLE`, default 2: zero-input cycles between stage 1 and stage 2.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; begins a test when in IDLE or DONE; ignored otherwise.
- `in_array` out 256: walking-one pattern to the MAC slice.
- `weight_array` out 1024: 256×4-bit weights to the MAC slice.
- `sum` in 16: MAC slice result.
- `busy` out 1: high in S1_RUN, GAP, S2_RUN.
- `done` out 1: high in DONE.
- `pass` out 1: valid with `done`; 1 = no fault found.
- `fault_type` out 3: 0 NONE, 1 SAF, 2 WIRED_AND, 3 DOMINANT, 4 DOMINANT_AND, 5 WIRED_OR.
- `fault_index` out 8: lane index at detection.
- `fault_weight` out 4: `sum[3:0]` captured for SAF; 0 otherwise.
- `fault_sum` out 16: raw `sum` at detection.

## Operation
- States: IDLE → S1_RUN → GAP → S2_RUN → DONE. Any detection goes directly to DONE.
- DONE → S1_RUN on `start`.
- Reset: state IDLE. All outputs 0: `in_array`, `weight_array`, flags, and fault fields.
- IDLE/DONE: `in_array`=0 and `weight_array`=0. Fault fields hold until the next `start`, then clear.
- S1_RUN:
  - `weight_array`=0; `in_array` has exactly bit `idx` set, with `idx` = 0..255.
  - At each sample edge: `sum`≠0 → SAF, `fault_weight`=`sum[3:0]`.
  - After index 255 with no fault → GAP.
- GAP: `in_array`=0 and `weight_array`=all ones for `SETTLE` cycles, then S2_RUN with `idx`=0.
- S2_RUN:
  - `weight_array`=all ones; walking one as in S1.
  - `prev` register initialised to 15 on entry. At each sample `cur`=`sum`; classify in priority order:
    - (0,0) → WIRED_AND
    - (30,0) or (0,30) → DOMINANT
    - (0,15) → DOMINANT_AND
    - (30,30) → WIRED_OR
  - With no match, `prev`←`cur` and continue. Unmatched values never stop the test.
  - After index 255 with no fault → DONE, `pass`=1.
- On detection: `fault_index`=current `idx`. For bridges this is the later lane of the pair. `pass`=0.
- Only the first fault is reported.
- `sum` is compared as unsigned 16-bit.

## Timing
- Pattern for `idx` is registered at edge E. The MAC captures at E+1. `sum` is sampled at E+`MAC_LATENCY`+1, the same edge that drives `idx`+1.
- Cost is `MAC_LATENCY`+1 cycles per index.
- With defaults, taking `start` at edge 0:
  - index i of S1 is sampled at edge 2i+2;
  - GAP runs edges 512–514;
  - S2 index i is sampled at 516+2i;
  - DONE/`done` is visible after edge 1026.
- Detection: DONE and the fault fields are visible after the sample edge; `in_array` returns to 0 the same edge.
- `rst` has priority over everything, including a simultaneous `start` or detection.
- Reset mid-test aborts without a report.

## Structure
- Package `mac_bist_pkg`:
  - state enum and fault-type enum;
  - `N_LANES`=256, `W_BITS`=4, `SUM_W`=16;
  - `EXP_ONE`=15, `EXP_TWO`=30.
- Sub-module `mac_bist_onehot`: registered 8→256 one-hot decoder with zero-force input, used for `in_array`.
- Latency counter width is `$clog2(MAC_LATENCY+2)`. Index counter is 8 bits and must not wrap silently; the last-index flag decides the transition.

## Test plan
- Fault-free MAC model (`sum`=Σ in·weight, 1-cycle registered) → `done` after edge 1026, `pass`=1, `fault_type`=0, `busy` low after.
- SAF on lane 11 stuck 4'b1111 → S1 sample at edge 24 gives `fault_type`=1, `fault_index`=11, `fault_weight`=4'hF, `fault_sum`=15, `pass`=0.
- Bridge lanes 20/21, S2 sums 0 then 0 → WIRED_AND, index 21. Sums 30,30 → WIRED_OR, index 21.
- S2 sums 30 then 0 → DOMINANT, index 21. Sums 0 then 15 → DOMINANT_AND, index 21.
- Single isolated S2 `sum`=7 at lane 40, all else 15 → no stop, `pass`=1, showing `prev` tracks `cur`.
- `rst` asserted at S2 index 100 → all outputs 0 next edge. `start` during `busy` is ignored. A second `start` from DONE clears fields and reruns with identical timing.
